// File: rtl/if_fetch_ctrl.sv
// Fetch-stage PC sequencer with a one-entry instruction holding buffer for the RV32 pipeline.
// Optional macro IF_BTFN_EN: static backward-taken / forward-not-taken branch prediction.
module if_fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            ifu_req_valid_o,
  output logic [XLEN-1:0] ifu_req_addr_o,
  input  logic            ifu_req_ready_i,
  input  logic            ifu_rsp_valid_i,
  input  logic [31:0]     ifu_rsp_instr_i,
  input  logic            mini_dec_jal_i,
  input  logic            mini_dec_jalr_i,
  input  logic            mini_dec_branch_i,
  input  logic [4:0]      mini_dec_rs1_idx_i,
  input  logic [XLEN-1:0] mini_dec_imm_i,
  output logic [4:0]      rf_rs1_idx_o,
  input  logic [XLEN-1:0] rf_rs1_rdata_i,
  input  logic            rs1_busy_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_redirect_pc_i,
  output logic            if_valid_o,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            if_pred_taken_o,
  output logic [XLEN-1:0] if_pred_pc_o,
  input  logic            id_ready_i
);

  typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            req_valid_q, req_valid_d;
  logic            if_valid_q, if_valid_d;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic            stall;
  logic            xfer;

  // Next-PC prediction from the mini decoder's view of the held instruction.
  always_comb begin
    rs1_val    = (mini_dec_rs1_idx_i == 5'd0) ? '0 : rf_rs1_rdata_i;
    pred_taken = 1'b0;
    pred_pc    = pc_q + XLEN'(4);
    if (mini_dec_jal_i) begin
      pred_taken = 1'b1;
      pred_pc    = pc_q + mini_dec_imm_i;
    end else if (mini_dec_jalr_i) begin
      pred_taken = 1'b1;
      pred_pc    = (rs1_val + mini_dec_imm_i) & ~XLEN'(1);
    end
`ifdef IF_BTFN_EN
    else if (mini_dec_branch_i && mini_dec_imm_i[XLEN-1]) begin
      pred_taken = 1'b1;
      pred_pc    = pc_q + mini_dec_imm_i;
    end
`endif
    if (pred_taken) pred_pc[1] = 1'b0;
  end

`ifndef IF_BTFN_EN
  logic unused_branch;
  assign unused_branch = mini_dec_branch_i;
`endif

  assign stall = mini_dec_jalr_i & rs1_busy_i & (mini_dec_rs1_idx_i != 5'd0);
  assign xfer  = id_ready_i & ~stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_BOOT:  state_d = S_REQ;
      S_REQ:   if (ifu_req_ready_i) state_d = S_WAIT;
      S_WAIT:  if (ifu_rsp_valid_i) begin
                 instr_d = ifu_rsp_instr_i;
                 state_d = S_HOLD;
               end
      S_HOLD:  if (xfer) begin
                 pc_d    = pred_pc;
                 state_d = S_REQ;
               end
      S_FLUSH: if (ifu_rsp_valid_i) state_d = S_REQ;
      default: state_d = S_BOOT;
    endcase
    // A redirect wins over everything; an in-flight response must still be drained.
    if (ex_redirect_i) begin
      pc_d    = ex_redirect_pc_i;
      instr_d = instr_q;
      unique case (state_q)
        S_REQ:   state_d = ifu_req_ready_i ? S_FLUSH : S_REQ;
        S_WAIT:  state_d = ifu_rsp_valid_i ? S_REQ : S_FLUSH;
        S_FLUSH: state_d = ifu_rsp_valid_i ? S_REQ : S_FLUSH;
        default: state_d = S_REQ;
      endcase
    end
    req_valid_d = (state_d == S_REQ);
    if_valid_d  = (state_d == S_HOLD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      req_valid_q <= req_valid_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign ifu_req_valid_o = req_valid_q;
  assign ifu_req_addr_o  = req_valid_q ? pc_q : '0;
  assign if_valid_o      = if_valid_q;
  assign if_instr_o      = instr_q;
  assign if_pc_o         = pc_q;
  assign if_pred_taken_o = if_valid_q & pred_taken;
  assign if_pred_pc_o    = if_valid_q ? pred_pc : '0;
  assign rf_rs1_idx_o    = if_valid_q ? mini_dec_rs1_idx_i : 5'd0;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed plus randomized bench for if_fetch_ctrl against a target-arithmetic reference model.
module tb_if_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int K_ALU = 0, K_JAL = 1, K_JALR = 2, K_BR = 3;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ifu_req_valid_o;
  logic [31:0] ifu_req_addr_o;
  logic        ifu_req_ready_i;
  logic        ifu_rsp_valid_i;
  logic [31:0] ifu_rsp_instr_i;
  logic        mini_dec_jal_i, mini_dec_jalr_i, mini_dec_branch_i;
  logic [4:0]  mini_dec_rs1_idx_i;
  logic [31:0] mini_dec_imm_i;
  logic [4:0]  rf_rs1_idx_o;
  logic [31:0] rf_rs1_rdata_i;
  logic        rs1_busy_i;
  logic        ex_redirect_i;
  logic [31:0] ex_redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        if_pred_taken_o;
  logic [31:0] if_pred_pc_o;
  logic        id_ready_i;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] held_instr;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .ifu_req_valid_o    (ifu_req_valid_o),
    .ifu_req_addr_o     (ifu_req_addr_o),
    .ifu_req_ready_i    (ifu_req_ready_i),
    .ifu_rsp_valid_i    (ifu_rsp_valid_i),
    .ifu_rsp_instr_i    (ifu_rsp_instr_i),
    .mini_dec_jal_i     (mini_dec_jal_i),
    .mini_dec_jalr_i    (mini_dec_jalr_i),
    .mini_dec_branch_i  (mini_dec_branch_i),
    .mini_dec_rs1_idx_i (mini_dec_rs1_idx_i),
    .mini_dec_imm_i     (mini_dec_imm_i),
    .rf_rs1_idx_o       (rf_rs1_idx_o),
    .rf_rs1_rdata_i     (rf_rs1_rdata_i),
    .rs1_busy_i         (rs1_busy_i),
    .ex_redirect_i      (ex_redirect_i),
    .ex_redirect_pc_i   (ex_redirect_pc_i),
    .if_valid_o         (if_valid_o),
    .if_instr_o         (if_instr_o),
    .if_pc_o            (if_pc_o),
    .if_pred_taken_o    (if_pred_taken_o),
    .if_pred_pc_o       (if_pred_pc_o),
    .id_ready_i         (id_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Where the fetch stream should go next, straight from the ISA-level rules.
  function automatic logic [31:0] ref_target(input int kind, input logic [31:0] pc,
                                             input logic [31:0] imm, input logic [4:0] idx,
                                             input logic [31:0] rdata, output logic taken);
    logic [31:0] t;
    taken = 1'b0;
    t     = pc + 32'd4;
    case (kind)
      K_JAL:  begin taken = 1'b1; t = pc + imm; end
      K_JALR: begin taken = 1'b1; t = ((idx == 5'd0) ? 32'd0 : rdata) + imm; t[0] = 1'b0; end
      K_BR: begin
`ifdef IF_BTFN_EN
        if ($signed(imm) < 0) begin taken = 1'b1; t = pc + imm; end
`endif
      end
      default: ;
    endcase
    if (taken) t[1] = 1'b0;
    return t;
  endfunction

  task automatic clear_dec;
    mini_dec_jal_i = 1'b0; mini_dec_jalr_i = 1'b0; mini_dec_branch_i = 1'b0;
    mini_dec_rs1_idx_i = 5'd0; mini_dec_imm_i = 32'd0; rf_rs1_rdata_i = 32'd0;
  endtask

  // Entered in REQ; leaves with the request accepted (WAIT).
  task automatic do_req(input int rdly);
    ifu_req_ready_i = 1'b0;
    #1;
    check("req_valid", 32'(ifu_req_valid_o), 32'd1);
    check("req_addr", ifu_req_addr_o, exp_pc);
    check("req_ifv", 32'(if_valid_o), 32'd0);
    for (int i = 0; i < rdly; i++) begin
      tick; #1;
      check("req_wait_valid", 32'(ifu_req_valid_o), 32'd1);
      check("req_wait_addr", ifu_req_addr_o, exp_pc);
    end
    ifu_req_ready_i = 1'b1;
    tick;
    ifu_req_ready_i = 1'b0;
  endtask

  // Entered in WAIT; leaves with the instruction held (HOLD).
  task automatic do_rsp(input int sdly, input logic [31:0] instr);
    ifu_rsp_valid_i = 1'b0;
    #1;
    check("wait_req", 32'(ifu_req_valid_o), 32'd0);
    check("wait_ifv", 32'(if_valid_o), 32'd0);
    for (int i = 0; i < sdly; i++) begin
      tick; #1;
      check("wait_req2", 32'(ifu_req_valid_o), 32'd0);
    end
    ifu_rsp_valid_i = 1'b1;
    ifu_rsp_instr_i = instr;
    held_instr      = instr;
    tick;
    ifu_rsp_valid_i = 1'b0;
    ifu_rsp_instr_i = $urandom;
  endtask

  task automatic hold_chk(input string tag, input logic tk, input logic [31:0] tgt,
                          input logic [4:0] idx);
    check({tag, "_vld"}, 32'(if_valid_o), 32'd1);
    check({tag, "_req"}, 32'(ifu_req_valid_o), 32'd0);
    check({tag, "_instr"}, if_instr_o, held_instr);
    check({tag, "_pc"}, if_pc_o, exp_pc);
    check({tag, "_ptk"}, 32'(if_pred_taken_o), 32'(tk));
    check({tag, "_ppc"}, if_pred_pc_o, tgt);
    check({tag, "_rfidx"}, 32'(rf_rs1_idx_o), 32'(idx));
  endtask

  // Entered in HOLD; leaves after the ID transfer (REQ) with exp_pc advanced.
  task automatic do_hold(input int kind, input logic [31:0] imm, input logic [4:0] idx,
                         input logic [31:0] rdata, input int busy, input int idw);
    logic        tk;
    logic [31:0] tgt;
    bit          stl;
    tgt = ref_target(kind, exp_pc, imm, idx, rdata, tk);
    stl = (kind == K_JALR) && (idx != 5'd0) && (busy > 0);
    mini_dec_jal_i     = (kind == K_JAL);
    mini_dec_jalr_i    = (kind == K_JALR);
    mini_dec_branch_i  = (kind == K_BR);
    mini_dec_rs1_idx_i = idx;
    mini_dec_imm_i     = imm;
    rf_rs1_rdata_i     = rdata;
    id_ready_i = 1'b0;
    rs1_busy_i = 1'b0;
    #1;
    hold_chk("hold", tk, tgt, idx);
    for (int i = 0; i < idw; i++) begin
      tick; #1;
      hold_chk("hold_idw", tk, tgt, idx);
    end
    id_ready_i = 1'b1;
    rs1_busy_i = (busy > 0);
    if (stl) begin
      for (int i = 0; i < busy; i++) begin
        tick; #1;
        hold_chk("hold_stall", tk, tgt, idx);
      end
      rs1_busy_i = 1'b0;
    end
    tick;
    id_ready_i = 1'b0;
    rs1_busy_i = 1'b0;
    clear_dec;
    exp_pc = tgt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, v;
    logic [31:0] t5_exp;
    rst_i = 1'b1;
    ifu_req_ready_i = 1'b0; ifu_rsp_valid_i = 1'b0; ifu_rsp_instr_i = 32'd0;
    rs1_busy_i = 1'b0; ex_redirect_i = 1'b0; ex_redirect_pc_i = 32'd0; id_ready_i = 1'b0;
    clear_dec;
    mini_dec_jal_i = 1'b1; mini_dec_rs1_idx_i = 5'd7;
    held_instr = 32'd0;
    repeat (3) tick;
    #1;
    check("rst_req_valid", 32'(ifu_req_valid_o), 32'd0);
    check("rst_req_addr", ifu_req_addr_o, 32'd0);
    check("rst_if_valid", 32'(if_valid_o), 32'd0);
    check("rst_instr", if_instr_o, 32'd0);
    check("rst_pc", if_pc_o, RST_PC);
    check("rst_ptk", 32'(if_pred_taken_o), 32'd0);
    check("rst_ppc", if_pred_pc_o, 32'd0);
    check("rst_rfidx", 32'(rf_rs1_idx_o), 32'd0);
    clear_dec;
    rst_i = 1'b0;
    #1;
    check("boot_req", 32'(ifu_req_valid_o), 32'd0);
    tick;
    exp_pc = RST_PC;

    // Boot fetch with zero-latency memory, then the JAL/BEQ/JALR scenarios.
    do_req(0);
    do_rsp(0, 32'h0100_006f);
    do_hold(K_JAL, 32'h10, 5'd0, 32'd0, 0, 0);
    #1 check("t2_addr", ifu_req_addr_o, 32'h8000_0010);
    do_req(0); do_rsp(0, 32'h0100_006f);
    do_hold(K_JAL, 32'h10, 5'd0, 32'd0, 0, 0);
    do_req(1); do_rsp(1, 32'hfe00_0ce3);
    do_hold(K_BR, 32'hffff_fff8, 5'd0, 32'd0, 0, 0);
`ifdef IF_BTFN_EN
    t5_exp = 32'h8000_0018;
`else
    t5_exp = 32'h8000_0024;
`endif
    #1 check("t3_addr", ifu_req_addr_o, t5_exp);
    do_req(0); do_rsp(0, 32'h0042_8067);
    do_hold(K_JALR, 32'd4, 5'd5, 32'h8000_1001, 3, 0);
    #1 check("t4_addr", ifu_req_addr_o, 32'h8000_1004);

    // Redirect while waiting; response lands two cycles later and must be dropped.
    do_req(0);
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0400;
    tick;
    ex_redirect_i = 1'b0;
    #1 check("t5_flush_req", 32'(ifu_req_valid_o), 32'd0);
    tick;
    ifu_rsp_valid_i = 1'b1;
    #1 check("t5_flush_ifv", 32'(if_valid_o), 32'd0);
    tick;
    ifu_rsp_valid_i = 1'b0;
    #1;
    check("t5_ifv", 32'(if_valid_o), 32'd0);
    check("t5_addr", ifu_req_addr_o, 32'h8000_0400);
    exp_pc = 32'h8000_0400;

    // ID back-pressure in HOLD, then a redirect that must beat the ID handshake.
    do_req(2); do_rsp(2, 32'h0200_006f);
    mini_dec_jal_i = 1'b1; mini_dec_imm_i = 32'h20;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick; #1;
      hold_chk("t6_hold", 1'b1, exp_pc + 32'h20, 5'd0);
    end
    id_ready_i = 1'b1; ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0800;
    tick;
    id_ready_i = 1'b0; ex_redirect_i = 1'b0;
    clear_dec;
    #1;
    check("t6_ifv", 32'(if_valid_o), 32'd0);
    check("t6_addr", ifu_req_addr_o, 32'h8000_0800);
    exp_pc = 32'h8000_0800;

    // Redirect in REQ without acceptance: re-request at the new target.
    ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0a00;
    tick;
    ex_redirect_i = 1'b0;
    #1 check("t7_addr", ifu_req_addr_o, 32'h8000_0a00);

    // Redirect with acceptance, then a second redirect during the flush.
    ifu_req_ready_i = 1'b1; ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0b00;
    tick;
    ifu_req_ready_i = 1'b0; ex_redirect_pc_i = 32'h8000_0c00;
    #1 check("t8_flush_req", 32'(ifu_req_valid_o), 32'd0);
    tick;
    ex_redirect_i = 1'b0;
    #1 check("t8_flush_req2", 32'(ifu_req_valid_o), 32'd0);
    ifu_rsp_valid_i = 1'b1;
    tick;
    ifu_rsp_valid_i = 1'b0;
    #1;
    check("t8_ifv", 32'(if_valid_o), 32'd0);
    check("t8_addr", ifu_req_addr_o, 32'h8000_0c00);
    exp_pc = 32'h8000_0c00;

    // Redirect colliding with the response in WAIT.
    do_req(0);
    ifu_rsp_valid_i = 1'b1; ex_redirect_i = 1'b1; ex_redirect_pc_i = 32'h8000_0d00;
    tick;
    ifu_rsp_valid_i = 1'b0; ex_redirect_i = 1'b0;
    #1;
    check("t9_ifv", 32'(if_valid_o), 32'd0);
    check("t9_addr", ifu_req_addr_o, 32'h8000_0d00);
    exp_pc = 32'h8000_0d00;

    // Reset mid-transaction; a stale response afterwards is ignored.
    do_req(0);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0; ifu_rsp_valid_i = 1'b1;
    #1 check("t10_pc", if_pc_o, RST_PC);
    tick;
    ifu_rsp_valid_i = 1'b0;
    #1;
    check("t10_ifv", 32'(if_valid_o), 32'd0);
    check("t10_addr", ifu_req_addr_o, RST_PC);
    exp_pc = RST_PC;

    // Random instruction stream.
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 3));
      v    = int'($urandom_range(0, 127)) * 2 - 128;
      do_req(int'($urandom_range(0, 2)));
      do_rsp(int'($urandom_range(0, 2)), $urandom);
      do_hold(kind, 32'(v), 5'($urandom_range(0, 7)), $urandom,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    do_req(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
